// File: rtl/weight_fetch_scheduler.sv
// Arbitrates one shared weight-BRAM read port among NUM_REQ burst loaders and streams back tagged words.
// Round robin by default; define WEIGHT_SCHED_FIXED_PRIO_EN for lowest-index-wins priority.
module weight_fetch_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 18,
   parameter int LEN_W      = 16,
   parameter int W          = 8,
   parameter int BRAM_LAT   = 2,
   parameter int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base,
   input  logic [NUM_REQ*LEN_W-1:0]      req_len,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            done,
   output logic                          busy,
   output logic                          bram_en,
   output logic                          bram_ren,
   output logic [ADDR_WIDTH-1:0]         bram_addr,
   input  logic [W-1:0]                  bram_dout,
   output logic [W-1:0]                  rd_data,
   output logic                          rd_valid,
   output logic [ID_W-1:0]               rd_id,
   output logic                          rd_last
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

   state_t                  state, state_nxt;
   logic [ID_W-1:0]         ptr;
   logic [ID_W-1:0]         cur_id;
   logic [ID_W-1:0]         win_id;
   logic                    win_found;
   logic [ADDR_WIDTH-1:0]   win_base;
   logic [LEN_W-1:0]        win_len;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [LEN_W-1:0]        rem_q;
   logic                    issue;
   logic                    issue_last;
   logic [BRAM_LAT-1:0]     tag_v;
   logic [BRAM_LAT-1:0]     tag_last;
   logic [ID_W-1:0]         tag_id [BRAM_LAT];
   logic [ADDR_WIDTH-1:0]   base_arr [NUM_REQ];
   logic [LEN_W-1:0]        len_arr  [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign base_arr[g] = req_base[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign len_arr[g]  = req_len[g*LEN_W +: LEN_W];
   end

   always_comb begin
      logic [ID_W-1:0] idx;
      idx       = '0;
      win_found = 1'b0;
      win_id    = '0;
`ifdef WEIGHT_SCHED_FIXED_PRIO_EN
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = ID_W'(i);
         if (req[idx]) begin
            win_found = 1'b1;
            win_id    = idx;
         end
      end
`else
      // Scan upward from the pointer with wrap; first hit wins.
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = ID_W'((int'(ptr) + i) % NUM_REQ);
         if (!win_found && req[idx]) begin
            win_found = 1'b1;
            win_id    = idx;
         end
      end
`endif
   end

   assign win_base = base_arr[win_id];
   assign win_len  = len_arr[win_id];
   assign busy     = (state != IDLE);

   always_comb begin
      state_nxt  = state;
      issue      = 1'b0;
      issue_last = 1'b0;
      bram_en    = 1'b0;
      bram_ren   = 1'b0;
      bram_addr  = '0;
      done       = '0;
      case (state)
         IDLE: begin
            if (win_found) state_nxt = (win_len == '0) ? FIN : ISSUE;
         end
         ISSUE: begin
            issue      = 1'b1;
            issue_last = (rem_q == LEN_W'(1));
            bram_en    = 1'b1;
            bram_ren   = 1'b1;
            bram_addr  = addr_q;
            if (issue_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            // Hold the port enabled until every issued read has left the tag pipe.
            bram_en = 1'b1;
            if (tag_v == '0) state_nxt = FIN;
         end
         FIN: begin
            done      = grant;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         cur_id   <= '0;
         grant    <= '0;
         addr_q   <= '0;
         rem_q    <= '0;
         tag_v    <= '0;
         tag_last <= '0;
         for (int i = 0; i < BRAM_LAT; i++) tag_id[i] <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_id    <= '0;
         rd_last  <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (win_found) begin
                  grant  <= NUM_REQ'(1) << win_id;
                  cur_id <= win_id;
                  addr_q <= win_base;
                  rem_q  <= win_len;
               end
            end
            ISSUE: begin
               addr_q <= addr_q + ADDR_WIDTH'(1);
               rem_q  <= rem_q - LEN_W'(1);
            end
            FIN: begin
               grant <= '0;
               ptr   <= (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + ID_W'(1);
            end
            default: ;
         endcase

         // Tags travel alongside the BRAM read latency so each word leaves with its owner.
         tag_v[0]    <= issue;
         tag_last[0] <= issue_last;
         tag_id[0]   <= cur_id;
         for (int i = 1; i < BRAM_LAT; i++) begin
            tag_v[i]    <= tag_v[i-1];
            tag_last[i] <= tag_last[i-1];
            tag_id[i]   <= tag_id[i-1];
         end

         rd_valid <= tag_v[BRAM_LAT-1];
         rd_last  <= tag_v[BRAM_LAT-1] & tag_last[BRAM_LAT-1];
         rd_id    <= tag_v[BRAM_LAT-1] ? tag_id[BRAM_LAT-1] : '0;
         rd_data  <= tag_v[BRAM_LAT-1] ? bram_dout : '0;
      end
   end

endmodule

// File: tb/tb_weight_fetch_scheduler.sv
// Randomized and directed bench for weight_fetch_scheduler against a burst-level reference model.
`timescale 1ns/1ps
module tb_weight_fetch_scheduler;
   localparam int NR  = 4;
   localparam int AW  = 18;
   localparam int LW  = 16;
   localparam int DW  = 8;
   localparam int LAT = 2;
   localparam int IW  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req;
   logic [NR*AW-1:0]  req_base;
   logic [NR*LW-1:0]  req_len;
   logic [NR-1:0]     grant;
   logic [NR-1:0]     done;
   logic              busy;
   logic              bram_en;
   logic              bram_ren;
   logic [AW-1:0]     bram_addr;
   logic [DW-1:0]     bram_dout;
   logic [DW-1:0]     bram_p1;
   logic [DW-1:0]     rd_data;
   logic              rd_valid;
   logic [IW-1:0]     rd_id;
   logic              rd_last;
   logic [40:0]       all_outs;

   int                n_chk  = 0;
   int                n_fail = 0;
   int                ptr_m  = 0;
   logic [AW-1:0]     base_a [NR];
   logic [LW-1:0]     len_a  [NR];

   weight_fetch_scheduler #(
      .NUM_REQ(NR), .ADDR_WIDTH(AW), .LEN_W(LW), .W(DW), .BRAM_LAT(LAT), .ID_W(IW)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .req_base(req_base), .req_len(req_len),
      .grant(grant), .done(done), .busy(busy), .bram_en(bram_en), .bram_ren(bram_ren),
      .bram_addr(bram_addr), .bram_dout(bram_dout), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_id(rd_id), .rd_last(rd_last)
   );

   always #5 clk = ~clk;

   assign all_outs = {grant, done, busy, bram_en, bram_ren, bram_addr, rd_valid, rd_id, rd_last, rd_data};

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8] ^ {6'b0, a[17:16]} ^ 8'hA5;
   endfunction

   // Two-cycle read latency memory image.
   always @(posedge clk) begin
      bram_p1   <= bram_ren ? mem_word(bram_addr) : '0;
      bram_dout <= bram_p1;
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic load(input int id, input logic [AW-1:0] b, input logic [LW-1:0] l);
      base_a[id]             = b;
      len_a[id]              = l;
      req_base[id*AW +: AW]  = b;
      req_len[id*LW +: LW]   = l;
      req[id]                = 1'b1;
   endtask

   function automatic int pick(input logic [NR-1:0] r, input int p);
`ifdef WEIGHT_SCHED_FIXED_PRIO_EN
      for (int i = 0; i < NR; i++) if (r[i]) return i;
`else
      for (int i = 0; i < NR; i++) if (r[(p + i) % NR]) return (p + i) % NR;
`endif
      return -1;
   endfunction

   // Checks one whole burst cycle by cycle against the timing rules, starting at the grant.
   task automatic run_burst(input bit drop, input bit scramble);
      int            w, last_c, wait_n;
      bit            rv;
      logic [AW-1:0] b, a;
      logic [LW-1:0] l;
      logic [NR-1:0] oh;
      w = pick(req, ptr_m);
      if (w < 0) begin
         chk("no_request", 0, 1);
         return;
      end
      b      = base_a[w];
      l      = len_a[w];
      oh     = NR'(1) << w;
      last_c = (l == '0) ? 0 : int'(l) + LAT + 1;
      wait_n = 0;
      while (grant == '0 && wait_n < 8) begin
         @(negedge clk);
         wait_n++;
      end
      if (grant == '0) begin
         chk("grant_timeout", 64'(grant), 64'(oh));
         return;
      end
      for (int c = 0; c <= last_c; c++) begin
         chk("grant", 64'(grant), 64'(oh));
         chk("busy", 64'(busy), 64'(1));
         chk("bram_ren", 64'(bram_ren), 64'(c < int'(l)));
         if (c < int'(l)) begin
            chk("bram_en", 64'(bram_en), 64'(1));
            chk("bram_addr", 64'(bram_addr), 64'(AW'(b + AW'(c))));
         end
         rv = (c >= LAT + 1) && (c < int'(l) + LAT + 1);
         chk("rd_valid", 64'(rd_valid), 64'(rv));
         if (rv) begin
            a = b + AW'(c - LAT - 1);
            chk("rd_id", 64'(rd_id), 64'(w));
            chk("rd_data", 64'(rd_data), 64'(mem_word(a)));
            chk("rd_last", 64'(rd_last), 64'(c == int'(l) + LAT));
         end
         chk("done", 64'(done), 64'((c == last_c) ? oh : '0));
         if (scramble && c == 0) begin
            req_base[w*AW +: AW] = ~b;
            req_len[w*LW +: LW]  = l + LW'(5);
            req[w]               = 1'b0;
         end
         if (drop && c == last_c) req[w] = 1'b0;
         @(negedge clk);
      end
      chk("idle_grant", 64'(grant), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_done", 64'(done), 64'(0));
      chk("idle_rd_valid", 64'(rd_valid), 64'(0));
      ptr_m = (w + 1) % NR;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] b;
      int            wait_n;
      rst      = 1'b1;
      req      = '0;
      req_base = '0;
      req_len  = '0;
      for (int i = 0; i < NR; i++) begin
         base_a[i] = '0;
         len_a[i]  = '0;
      end
      repeat (3) @(negedge clk);
      chk("reset_outs", 64'(all_outs), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_outs", 64'(all_outs), 64'(0));

      // Single burst; latched fields must survive req drop and base/len change.
      load(1, AW'(46080), LW'(4));
      run_burst(1'b0, 1'b1);
      repeat (3) @(negedge clk);
      chk("no_regrant", 64'(grant), 64'(0));

      // Round robin with all four held.
      rst = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      ptr_m = 0;
      for (int i = 0; i < NR; i++) load(i, AW'($urandom), LW'(2));
      for (int k = 0; k < 5; k++) run_burst(1'b0, 1'b0);
      req = '0;
      @(negedge clk);

      // Zero length, then address wrap.
      load(2, AW'($urandom), LW'(0));
      run_burst(1'b1, 1'b0);
      load(2, AW'(262142), LW'(4));
      run_burst(1'b1, 1'b0);

      // Reset in the middle of a burst.
      b = AW'($urandom);
      load(3, b, LW'(8));
      wait_n = 0;
      while (grant == '0 && wait_n < 8) begin
         @(negedge clk);
         wait_n++;
      end
      chk("mid_grant", 64'(grant), 64'(NR'(1) << pick(req, ptr_m)));
      repeat (2) @(negedge clk);
      chk("mid_addr3", 64'(bram_addr), 64'(AW'(b + AW'(2))));
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      chk("mid_reset_outs", 64'(all_outs), 64'(0));
      rst   = 1'b0;
      ptr_m = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("post_rst_quiet", 64'({rd_valid, done, grant}), 64'(0));
      end
      load(1, AW'($urandom), LW'($urandom_range(1, 5)));
      load(3, AW'($urandom), LW'($urandom_range(0, 5)));
      run_burst(1'b1, 1'b0);
      run_burst(1'b1, 1'b0);

`ifdef WEIGHT_SCHED_FIXED_PRIO_EN
      load(1, AW'($urandom), LW'(1));
      load(3, AW'($urandom), LW'(1));
      for (int k = 0; k < 3; k++) run_burst(1'b0, 1'b0);
      req[1] = 1'b0;
      run_burst(1'b1, 1'b0);
`endif

      // Randomized traffic: requesters join at idle and leave on their done pulse.
      req = '0;
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < NR; i++)
            if (!req[i] && $urandom_range(0, 2) == 0)
               load(i, AW'($urandom), LW'($urandom_range(0, 6)));
         if (req == '0) load(int'($urandom_range(0, NR - 1)), AW'($urandom), LW'($urandom_range(0, 6)));
         run_burst(1'b1, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
